id_ex_latch: RTL and testbench

- Pipeline register between the decode stage and the execute stage of the pipelined CPU.
- Captures the decoded instruction: PC+4, register-file read data, the 32-bit extended immediate from the decode-stage extender, register indices, ALU op and control bits.
- Detects load-use hazards against the instruction already in EX; on a hazard it inserts a bubble and stalls IF/ID.
- Also handles branch flush, downstream stall, a sticky halt, and a saturating bubble counter.

---
 rtl/id_ex_latch_if.sv | 53 +++++
 rtl/id_ex_latch.sv | 112 +++++++++++
 tb/tb_id_ex_latch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/id_ex_latch_if.sv
// ID/EX pipeline boundary: decode-side payload in, execute-side payload out.
interface id_ex_latch_if #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned AOP_W  = 4,
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned CNT_W  = 16
) ();

  logic              id_valid;
  logic [WORD_W-1:0] id_pcnext;
  logic [WORD_W-1:0] id_rdat1;
  logic [WORD_W-1:0] id_rdat2;
  logic [WORD_W-1:0] id_imm;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  logic [AOP_W-1:0]  id_aluop;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_stall;
  logic              flush;

  logic              ex_valid;
  logic [WORD_W-1:0] ex_pcnext;
  logic [WORD_W-1:0] ex_rdat1;
  logic [WORD_W-1:0] ex_rdat2;
  logic [WORD_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [AOP_W-1:0]  ex_aluop;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              id_stall;
  logic              halted;
  logic [CNT_W-1:0]  perf_bubbles;

  // Pipeline control / decode stage side
  modport master (
    output id_valid, id_pcnext, id_rdat1, id_rdat2, id_imm,
           id_rs, id_rt, id_rd, id_aluop, id_ctrl, ex_stall, flush,
    input  ex_valid, ex_pcnext, ex_rdat1, ex_rdat2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_aluop, ex_ctrl, id_stall, halted, perf_bubbles
  );

  // The latch itself
  modport slave (
    input  id_valid, id_pcnext, id_rdat1, id_rdat2, id_imm,
           id_rs, id_rt, id_rd, id_aluop, id_ctrl, ex_stall, flush,
    output ex_valid, ex_pcnext, ex_rdat1, ex_rdat2, ex_imm,
           ex_rs, ex_rt, ex_rd, ex_aluop, ex_ctrl, id_stall, halted, perf_bubbles
  );

endinterface

// File: rtl/id_ex_latch.sv
// ID/EX pipeline register with load-use bubble insertion, flush, stall,
// sticky halt and a saturating hazard-bubble counter.
module id_ex_latch #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned AOP_W  = 4,
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned CNT_W  = 16
) (
  input logic          CLK,
  input logic          RST,
  id_ex_latch_if.slave bus
);

  localparam int unsigned C_MEMREN = 1;
  localparam int unsigned C_MEMWEN = 2;
  localparam int unsigned C_ALUSRC = 4;
  localparam int unsigned C_HALT   = 6;

  typedef struct packed {
    logic              valid;
    logic [WORD_W-1:0] pcnext;
    logic [WORD_W-1:0] rdat1;
    logic [WORD_W-1:0] rdat2;
    logic [WORD_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [AOP_W-1:0]  aluop;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t           entry_q, entry_nxt, id_entry;
  logic             halted_q, halted_nxt;
  logic [CNT_W-1:0] perf_q, perf_nxt;
  logic             uses_rt;
  logic             hazard;

  // Decode-side payload; a non-valid instruction enters EX as a pure bubble
  always_comb begin
    id_entry = '0;
    if (bus.id_valid) begin
      id_entry.valid  = 1'b1;
      id_entry.pcnext = bus.id_pcnext;
      id_entry.rdat1  = bus.id_rdat1;
      id_entry.rdat2  = bus.id_rdat2;
      id_entry.imm    = bus.id_imm;
      id_entry.rs     = bus.id_rs;
      id_entry.rt     = bus.id_rt;
      id_entry.rd     = bus.id_rd;
      id_entry.aluop  = bus.id_aluop;
      id_entry.ctrl   = bus.id_ctrl;
    end
  end

  // Load-use detection: rt only matters when it is a real source (R-type or store)
  always_comb begin
    uses_rt = !bus.id_ctrl[C_ALUSRC] | bus.id_ctrl[C_MEMWEN];
    hazard  = bus.id_valid & entry_q.valid & entry_q.ctrl[C_MEMREN] &
              (entry_q.rt != '0) &
              ((bus.id_rs == entry_q.rt) | (uses_rt & (bus.id_rt == entry_q.rt)));
  end

  // Next-state selection in update priority order
  always_comb begin
    entry_nxt  = entry_q;
    halted_nxt = halted_q;
    perf_nxt   = perf_q;
    if (bus.flush) begin
      entry_nxt = '0;
    end else if (bus.ex_stall) begin
      entry_nxt = entry_q;
    end else if (halted_q) begin
      entry_nxt = '0;
    end else if (hazard) begin
      entry_nxt = '0;
      if (perf_q != {CNT_W{1'b1}}) perf_nxt = perf_q + CNT_W'(1);
    end else begin
      entry_nxt = id_entry;
    end
    if (entry_q.valid & entry_q.ctrl[C_HALT] & !bus.ex_stall & !bus.flush)
      halted_nxt = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      entry_q  <= '0;
      halted_q <= 1'b0;
      perf_q   <= '0;
    end else begin
      entry_q  <= entry_nxt;
      halted_q <= halted_nxt;
      perf_q   <= perf_nxt;
    end
  end

  assign bus.ex_valid     = entry_q.valid;
  assign bus.ex_pcnext    = entry_q.pcnext;
  assign bus.ex_rdat1     = entry_q.rdat1;
  assign bus.ex_rdat2     = entry_q.rdat2;
  assign bus.ex_imm       = entry_q.imm;
  assign bus.ex_rs        = entry_q.rs;
  assign bus.ex_rt        = entry_q.rt;
  assign bus.ex_rd        = entry_q.rd;
  assign bus.ex_aluop     = entry_q.aluop;
  assign bus.ex_ctrl      = entry_q.ctrl;
  assign bus.halted       = halted_q;
  assign bus.perf_bubbles = perf_q;
  assign bus.id_stall     = hazard | bus.ex_stall | halted_q;

endmodule

// File: tb/tb_id_ex_latch.sv
// Directed bench for id_ex_latch: main instance plus a 2-bit counter instance
// for counter saturation.
module tb_id_ex_latch;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLK = ~CLK;

  id_ex_latch_if #(.CNT_W(16)) bus ();
  id_ex_latch_if #(.CNT_W(2))  bus2 ();

  id_ex_latch #(.CNT_W(16)) dut  (.CLK(CLK), .RST(RST), .bus(bus));
  id_ex_latch #(.CNT_W(2))  dut2 (.CLK(CLK), .RST(RST), .bus(bus2));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [6:0] ctrl);
    bus.id_valid = v;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_ctrl  = ctrl;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    bus.id_valid = 0; bus.id_pcnext = 0; bus.id_rdat1 = 0; bus.id_rdat2 = 0;
    bus.id_imm = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_rd = 0;
    bus.id_aluop = 0; bus.id_ctrl = 0; bus.ex_stall = 0; bus.flush = 0;
    bus2.id_valid = 0; bus2.id_pcnext = 0; bus2.id_rdat1 = 0; bus2.id_rdat2 = 0;
    bus2.id_imm = 0; bus2.id_rs = 0; bus2.id_rt = 0; bus2.id_rd = 0;
    bus2.id_aluop = 0; bus2.id_ctrl = 0; bus2.ex_stall = 0; bus2.flush = 0;

    // Reset state
    tick();
    check("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
    check("rst_ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_perf", 64'(bus.perf_bubbles), 64'd0);
    RST = 1'b0;

    // Normal load
    bus.id_imm = 32'hFFFF_8000; bus.id_pcnext = 32'h104; bus.id_rdat1 = 32'hAA;
    bus.id_aluop = 4'd2;
    set_id(1'b1, 5'd3, 5'd4, 7'h11);
    check("load_id_stall", 64'(bus.id_stall), 64'd0);
    tick();
    check("load_ex_valid", 64'(bus.ex_valid), 64'd1);
    check("load_ex_imm", 64'(bus.ex_imm), 64'hFFFF_8000);
    check("load_ex_ctrl", 64'(bus.ex_ctrl), 64'h11);
    check("load_ex_rs", 64'(bus.ex_rs), 64'd3);
    check("load_ex_pcnext", 64'(bus.ex_pcnext), 64'h104);
    check("load_ex_aluop", 64'(bus.ex_aluop), 64'd2);

    // Load-use on rs
    set_id(1'b1, 5'd1, 5'd5, 7'h1B);
    tick();
    set_id(1'b1, 5'd5, 5'd6, 7'h01);
    check("lu_id_stall", 64'(bus.id_stall), 64'd1);
    tick();
    check("lu_bubble_valid", 64'(bus.ex_valid), 64'd0);
    check("lu_bubble_ctrl", 64'(bus.ex_ctrl), 64'd0);
    check("lu_perf", 64'(bus.perf_bubbles), 64'd1);
    check("lu_resolved_stall", 64'(bus.id_stall), 64'd0);
    tick();
    check("lu_load_valid", 64'(bus.ex_valid), 64'd1);
    check("lu_load_rs", 64'(bus.ex_rs), 64'd5);
    check("lu_load_ctrl", 64'(bus.ex_ctrl), 64'h01);

    // No false hazards against lw rt=5
    set_id(1'b1, 5'd1, 5'd5, 7'h1B);
    tick();
    set_id(1'b1, 5'd2, 5'd5, 7'h11);
    check("addi_rt_no_stall", 64'(bus.id_stall), 64'd0);
    set_id(1'b1, 5'd2, 5'd5, 7'h01);
    check("rtype_rt_stall", 64'(bus.id_stall), 64'd1);
    set_id(1'b1, 5'd2, 5'd5, 7'h14);
    check("sw_rt_stall", 64'(bus.id_stall), 64'd1);
    set_id(1'b0, 5'd5, 5'd5, 7'h01);
    check("invalid_id_no_stall", 64'(bus.id_stall), 64'd0);
    set_id(1'b1, 5'd2, 5'd5, 7'h11);
    tick();
    check("addi_loaded", 64'(bus.ex_valid), 64'd1);
    check("addi_perf", 64'(bus.perf_bubbles), 64'd1);

    // Load to $0 never hazards
    set_id(1'b1, 5'd9, 5'd0, 7'h1B);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 7'h01);
    check("zero_rt_no_stall", 64'(bus.id_stall), 64'd0);

    // Downstream stall holds EX, then flush wins over stall
    bus.id_pcnext = 32'h200; bus.id_rdat2 = 32'h55; bus.id_aluop = 4'd5;
    set_id(1'b1, 5'd3, 5'd7, 7'h01);
    tick();
    bus.ex_stall = 1'b1;
    bus.id_pcnext = 32'h300; bus.id_rdat2 = 32'h66; bus.id_aluop = 4'd9;
    set_id(1'b1, 5'd8, 5'd9, 7'h11);
    check("stall_id_stall", 64'(bus.id_stall), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_hold_pcnext", 64'(bus.ex_pcnext), 64'h200);
      check("stall_hold_rdat2", 64'(bus.ex_rdat2), 64'h55);
      check("stall_hold_aluop", 64'(bus.ex_aluop), 64'd5);
      check("stall_hold_valid", 64'(bus.ex_valid), 64'd1);
    end
    bus.flush = 1'b1;
    tick();
    check("flush_valid", 64'(bus.ex_valid), 64'd0);
    check("flush_ctrl", 64'(bus.ex_ctrl), 64'd0);
    check("flush_pcnext", 64'(bus.ex_pcnext), 64'd0);
    check("flush_perf", 64'(bus.perf_bubbles), 64'd1);
    bus.flush = 1'b0; bus.ex_stall = 1'b0;

    // id_valid=0 loads a bubble with ctrl forced to 0
    set_id(1'b0, 5'd1, 5'd2, 7'h1F);
    tick();
    check("idle_valid", 64'(bus.ex_valid), 64'd0);
    check("idle_ctrl", 64'(bus.ex_ctrl), 64'd0);
    check("idle_pcnext", 64'(bus.ex_pcnext), 64'd0);

    // Hazard together with ex_stall: hold, no count
    set_id(1'b1, 5'd1, 5'd5, 7'h1B);
    tick();
    bus.ex_stall = 1'b1;
    set_id(1'b1, 5'd5, 5'd6, 7'h01);
    check("hz_stall_id_stall", 64'(bus.id_stall), 64'd1);
    tick();
    check("hz_stall_hold_valid", 64'(bus.ex_valid), 64'd1);
    check("hz_stall_hold_rt", 64'(bus.ex_rt), 64'd5);
    check("hz_stall_perf", 64'(bus.perf_bubbles), 64'd1);
    bus.ex_stall = 1'b0;
    #1;
    tick();
    check("hz_after_valid", 64'(bus.ex_valid), 64'd0);
    check("hz_after_perf", 64'(bus.perf_bubbles), 64'd2);

    // Sticky halt
    set_id(1'b1, 5'd0, 5'd0, 7'h40);
    tick();
    check("halt_entry_ctrl", 64'(bus.ex_ctrl), 64'h40);
    check("halt_not_yet", 64'(bus.halted), 64'd0);
    set_id(1'b0, 5'd0, 5'd0, 7'h00);
    tick();
    check("halt_set", 64'(bus.halted), 64'd1);
    set_id(1'b1, 5'd1, 5'd2, 7'h01);
    for (int i = 0; i < 10; i++) begin
      check("halt_id_stall", 64'(bus.id_stall), 64'd1);
      tick();
      check("halt_bubble_valid", 64'(bus.ex_valid), 64'd0);
      check("halt_sticky", 64'(bus.halted), 64'd1);
    end
    check("halt_perf_unchanged", 64'(bus.perf_bubbles), 64'd2);
    RST = 1'b1;
    tick();
    check("rst_clears_halted", 64'(bus.halted), 64'd0);
    check("rst_clears_perf", 64'(bus.perf_bubbles), 64'd0);
    check("rst_clears_valid", 64'(bus.ex_valid), 64'd0);
    RST = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 7'h00);

    // Saturation on the 2-bit counter: back-to-back dependent loads
    bus2.id_valid = 1'b1; bus2.id_rs = 5'd5; bus2.id_rt = 5'd5; bus2.id_ctrl = 7'h1B;
    for (int i = 0; i < 4; i++) tick();
    check("sat_two_hazards", 64'(bus2.perf_bubbles), 64'd2);
    for (int i = 0; i < 2; i++) tick();
    check("sat_three_hazards", 64'(bus2.perf_bubbles), 64'd3);
    for (int i = 0; i < 6; i++) tick();
    check("sat_no_wrap", 64'(bus2.perf_bubbles), 64'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
